// File: rtl/vc_mac_dot_ctrl.sv
// Dot-product sequencer: streams N operand pairs from memory into an external MAC and returns the sum.
// Optional abort input is built in when VC_MAC_DOT_CTRL_ABORT_EN is defined.
module vc_mac_dot_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int MEM_LATENCY = 1,
  parameter int MAC_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef VC_MAC_DOT_CTRL_ABORT_EN
  input  logic                  abort,
`endif
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [ADDR_WIDTH:0]   start_len,
  input  logic [ADDR_WIDTH-1:0] start_a_base,
  input  logic [ADDR_WIDTH-1:0] start_b_base,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_a_addr,
  output logic [ADDR_WIDTH-1:0] rd_b_addr,
  input  logic [DATA_WIDTH-1:0] rd_a_data,
  input  logic [DATA_WIDTH-1:0] rd_b_data,
  output logic                  mac_reset,
  output logic                  mac_en,
  output logic [DATA_WIDTH-1:0] mac_a,
  output logic [DATA_WIDTH-1:0] mac_b,
  input  logic [DATA_WIDTH-1:0] mac_q,
  output logic                  done_valid,
  input  logic                  done_ready,
  output logic [DATA_WIDTH-1:0] done_result
);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_e;

  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = 1;
  localparam logic [3:0]            DRAIN_LAST = 4'(MEM_LATENCY + MAC_LATENCY - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
  logic [ADDR_WIDTH:0]     len_q, len_d;
  logic [ADDR_WIDTH-1:0]   a_addr_q, a_addr_d;
  logic [ADDR_WIDTH-1:0]   b_addr_q, b_addr_d;
  logic [3:0]              drain_q, drain_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic [MEM_LATENCY-1:0]  en_pipe_q, en_pipe_d;
  logic                    rd_en_int, clr, abort_hit, abort_w;

`ifdef VC_MAC_DOT_CTRL_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    a_addr_d    = a_addr_q;
    b_addr_d    = b_addr_q;
    drain_d     = drain_q;
    result_d    = result_q;
    rd_en_int   = 1'b0;
    clr         = 1'b0;
    abort_hit   = 1'b0;
    start_ready = 1'b0;
    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          len_d    = start_len;
          a_addr_d = start_a_base;
          b_addr_d = start_b_base;
          cnt_d    = '0;
          if (start_len == '0) begin
            result_d = '0;
            state_d  = DONE;
          end else begin
            state_d  = CLEAR;
          end
        end
      end
      CLEAR: begin
        clr     = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        rd_en_int = 1'b1;
        a_addr_d  = a_addr_q + ADDR_ONE;
        b_addr_d  = b_addr_q + ADDR_ONE;
        cnt_d     = cnt_q + CNT_ONE;
        if (cnt_q == len_q - CNT_ONE) begin
          drain_d = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        drain_d = drain_q + 4'd1;
        // Last MAC update is visible here; capture it as the result.
        if (drain_q == DRAIN_LAST) begin
          result_d = mac_q;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort_w && (state_q == CLEAR || state_q == RUN || state_q == DRAIN)) begin
      abort_hit = 1'b1;
      state_d   = IDLE;
    end

    // mac_en tracks rd_en through the memory latency; abort drops in-flight enables.
    en_pipe_d[0] = rd_en_int;
    for (int i = 1; i < MEM_LATENCY; i++) en_pipe_d[i] = en_pipe_q[i-1];
    if (abort_hit) en_pipe_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      a_addr_q  <= '0;
      b_addr_q  <= '0;
      drain_q   <= '0;
      result_q  <= '0;
      en_pipe_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      a_addr_q  <= a_addr_d;
      b_addr_q  <= b_addr_d;
      drain_q   <= drain_d;
      result_q  <= result_d;
      en_pipe_q <= en_pipe_d;
    end
  end

  assign rd_en       = rd_en_int & ~reset;
  assign rd_a_addr   = a_addr_q;
  assign rd_b_addr   = b_addr_q;
  assign mac_en      = en_pipe_q[MEM_LATENCY-1] & ~reset;
  assign mac_a       = rd_a_data;
  assign mac_b       = rd_b_data;
  assign mac_reset   = reset | clr | abort_hit;
  assign done_valid  = (state_q == DONE) & ~reset;
  assign done_result = result_q;

endmodule

// File: doc/vc_mac_dot_ctrl.md
VC_MAC_DOT_CTRL -- requirements
Module: vc_mac_dot_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning operand/result width, matching the driven MAC.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning operand-memory address width.
REQ-003 SHALL have parameter MEM_LATENCY, default 1, meaning read-issue to read-data cycles, legal range 1..4.
REQ-004 SHALL have parameter MAC_LATENCY, default 2, meaning MAC en-in to q-updated cycles, legal range 1..8.
REQ-005 SHALL have port clk, input, 1, single clock; all state is updated on posedge clk.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports start_valid (input, 1) and start_ready (output, 1), the job-request handshake.
REQ-008 SHALL have port start_len, input, ADDR_WIDTH+1, element count N (0..2^ADDR_WIDTH).
REQ-009 SHALL have ports start_a_base and start_b_base, input, ADDR_WIDTH each, operand base addresses.
REQ-010 SHALL have ports rd_en (output, 1), rd_a_addr and rd_b_addr (output, ADDR_WIDTH), the memory read request.
REQ-011 SHALL have ports rd_a_data and rd_b_data, input, DATA_WIDTH, valid MEM_LATENCY cycles after rd_en.
REQ-012 SHALL have MAC ports mac_reset, mac_en (output, 1); mac_a, mac_b (output, DATA_WIDTH); mac_q (input, DATA_WIDTH).
REQ-013 SHALL have ports done_valid (output, 1), done_ready (input, 1) and done_result (output, DATA_WIDTH).

Function
REQ-014 SHALL implement FSM states IDLE, CLEAR, RUN, DRAIN, DONE.
REQ-015 SHALL drive start_ready=1 only in IDLE; a job is accepted on the cycle where start_valid and start_ready are both 1; N and both bases are latched at that point.
REQ-016 IDLE transitions: on accept with N>0 go to CLEAR; on accept with N=0 go to DONE with done_result=0 and no MAC activity.
REQ-017 CLEAR SHALL last exactly 1 cycle with mac_reset=1, then go to RUN.
REQ-018 RUN SHALL last exactly N cycles with rd_en=1 every cycle; addresses run base, base+1, ... and wrap modulo 2^ADDR_WIDTH.
REQ-019 SHALL drive mac_en equal to rd_en delayed MEM_LATENCY cycles; mac_a=rd_a_data and mac_b=rd_b_data combinationally.
REQ-020 After the last RUN cycle, DRAIN SHALL last exactly MEM_LATENCY+MAC_LATENCY cycles; mac_q is registered into done_result at the end of the last DRAIN cycle.
REQ-021 DONE SHALL hold done_valid=1 with done_result stable until done_ready=1, then go to IDLE on the next cycle. A start is not accepted in that same cycle.
REQ-022 SHALL truncate all products and sums to DATA_WIDTH (modulo 2^DATA_WIDTH), consistent with the MAC.
REQ-023 SHALL hold rd_en, mac_en and mac_reset at 0 in IDLE, DRAIN (except pipeline-delayed mac_en) and DONE.

Reset
REQ-024 Reset SHALL be synchronous: when reset=1 at a posedge, the FSM goes to IDLE and all counters and delay stages clear, regardless of state.
REQ-025 While in or after reset: start_ready=1 (IDLE), rd_en=0, mac_en=0, done_valid=0, done_result=0, addresses=0.
REQ-026 mac_reset SHALL be driven 1 in every cycle in which reset=1, so the MAC is cleared alongside the controller.
REQ-027 Reset during RUN or DRAIN SHALL discard the job with no done_valid pulse.

Configuration
REQ-028 Macro VC_MAC_DOT_CTRL_ABORT_EN: when defined, add input abort (1 bit).
REQ-029 With VC_MAC_DOT_CTRL_ABORT_EN defined, abort=1 in CLEAR, RUN or DRAIN goes to IDLE next cycle, drives mac_reset=1 for 1 cycle and flushes the mac_en delay stages, with no done_valid; abort is ignored in IDLE and DONE.
REQ-030 Without VC_MAC_DOT_CTRL_ABORT_EN, the abort port SHALL NOT exist and behaviour is identical to abort tied to 0.

Verification (MEM_LATENCY=1, MAC_LATENCY=2, model MAC and 1-cycle memory)
REQ-031 Dot product: N=4, A=[1,2,3,4], B=[5,6,7,8] at bases 0, accept at cycle s -> done_valid first at cycle s+9, done_result=70.
REQ-032 Wrap and zero: N=3, a_base=255, b_base=254 -> addresses 255,0,1 and 254,255,0; N=0 -> done_valid at s+1, result 0, rd_en never asserted.
REQ-033 Back-pressure and back-to-back: done_ready=0 for 5 cycles -> done_valid and result held, start_ready=0; second job (A=B=[2,2]) after release -> result 8, not accumulated onto the first.
REQ-034 Overflow: N=2, A=B=[0xFFFF_FFFF,2] -> done_result=0x0000_0005.
REQ-035 Reset mid-RUN of N=8 at cycle s+4 -> next cycle IDLE, rd_en=0, no done_valid; following job N=1, 3*3 -> result 9.
REQ-036 ABORT_EN build: abort=1 in DRAIN -> IDLE, mac_reset pulse, no done_valid; next job N=2, [1,1]x[1,1] -> result 2.
